result_pipe: RTL and testbench
==============================

RESULT_PIPE -- requirements
Module: result_pipe

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock, and all state SHALL update on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: the reset, which SHALL be asynchronous and active-low.
REQ-003 The block SHALL have the port hold, input, 1 bit: global pipeline stall, which freezes both stages.
REQ-004 The block SHALL have the port flush, input, 1 bit: inserts a bubble into EX/MEM.
REQ-005 The block SHALL have the port in_valid, input, 1 bit: the ID/EX instruction is valid.
REQ-006 The block SHALL have the ports in_rd, input, 5 bits; in_regWrite, input, 1 bit; in_memToReg, input, 1 bit: the ID/EX destination and control.
REQ-007 The block SHALL have the port in_alu, input, 32 bits: the EX-stage ALU result.
REQ-008 The block SHALL have the ports rs1_ID_EX and rs2_ID_EX, input, 5 bits each: the source registers of the instruction in EX.
REQ-009 The block SHALL have the port mem_rdata, input, 32 bits: data memory read data, valid during the MEM stage.
REQ-010 The block SHALL have the ports rd_EX_MEM, rd_MEM_WB, output, 5 bits each; regWrite_EX_MEM, regWrite_MEM_WB, output, 1 bit each: the tags consumed by the forwarding unit.
REQ-011 The block SHALL have the ports alu_EX_MEM, wb_data_MEM_WB, output, 32 bits each: the forwarding data sources.
REQ-012 The block SHALL have the ports rf_we, output, 1 bit; rf_waddr, output, 5 bits; rf_wdata, output, 32 bits: the register file write port.
REQ-013 The block SHALL have the port lu_stall, output, 1 bit: the load-use stall request to the upstream stages.

Function
REQ-014 EX/MEM SHALL register rd, regWrite, memToReg and alu, and MEM/WB SHALL register rd, regWrite and wb_data.
REQ-015 EX/MEM update priority SHALL be: hold (keep) > flush (bubble) > lu_stall (bubble) > capture inputs.
REQ-016 A bubble SHALL set rd=0, regWrite=0, memToReg=0 and alu=0.
REQ-017 On capture with in_valid=0, EX/MEM SHALL load a bubble.
REQ-018 MEM/WB SHALL keep its contents while hold=1; otherwise it SHALL capture EX/MEM, with wb_data = memToReg_EX_MEM ? mem_rdata : alu_EX_MEM.
REQ-019 flush SHALL NOT affect MEM/WB; the instruction leaving EX/MEM SHALL still retire.
REQ-020 lu_stall SHALL be combinational from registered state: regWrite_EX_MEM & memToReg_EX_MEM & rd_EX_MEM!=0 & in_valid & (rd_EX_MEM==rs1_ID_EX | rd_EX_MEM==rs2_ID_EX).
REQ-021 Because a bubble follows the load in EX/MEM, lu_stall SHALL deassert after exactly one cycle; back-to-back dependent loads SHALL each stall once.
REQ-022 lu_stall SHALL be forced to 0 while hold=1 or flush=1.
REQ-023 rf_we SHALL equal regWrite_MEM_WB & (rd_MEM_WB!=0); rf_waddr SHALL equal rd_MEM_WB; rf_wdata SHALL equal wb_data_MEM_WB.
REQ-024 Stored regWrite with rd=0 SHALL pass through unchanged; x0 filtering SHALL occur only at rf_we.
REQ-025 Latency from capture into EX/MEM to rf_we SHALL be 2 cycles absent hold.

Reset
REQ-026 When rst_n=0, all stage registers SHALL clear to 0 immediately, independent of clk, so that every output reads 0 (lu_stall=0, rf_we=0).
REQ-027 An asserted reset mid-operation SHALL discard in-flight instructions; normal capture SHALL resume on the first rising clk edge with rst_n=1.

Configuration
REQ-028 When the macro RESULT_PIPE_RETIRE_CNT_EN is defined, the block SHALL add the output retire_cnt, 32 bits, which resets to 0, increments by 1 on each clk edge where rf_we=1 and hold=0, and wraps from 0xFFFFFFFF to 0.
REQ-029 When RESULT_PIPE_RETIRE_CNT_EN is not defined, the retire_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Reset: with rst_n=0 asserted asynchronously mid-stream, all outputs SHALL read 0 before the next clk edge.
REQ-031 ALU chain: an instruction with rd=5, regWrite=1, alu=0x1234 SHALL appear as rd_EX_MEM=5 at cycle 1, and as rf_we=1, rf_waddr=5, rf_wdata=0x1234 at cycle 2.
REQ-032 Load-use: a load with rd=3 in EX/MEM and rs2_ID_EX=3 SHALL produce lu_stall=1 for one cycle, then EX/MEM=bubble, then MEM/WB wb_data=mem_rdata (0xDEADBEEF).
REQ-033 Hold: with hold=1 for 3 cycles, both stages SHALL stay frozen and lu_stall=0; the stages SHALL resume unchanged after hold drops.
REQ-034 x0 write: rd=0 with regWrite=1 and alu=0x55 SHALL give regWrite_MEM_WB=1 and rf_we=0.
REQ-035 Flush plus hold in the same cycle: hold SHALL win and EX/MEM SHALL keep its contents; when flush alone is asserted, EX/MEM SHALL become a bubble while MEM/WB retires normally.

Source files
------------

// File: rtl/result_pipe.sv
// ---------------------------------------------------------------------------
// result_pipe
//
// Back end of a five-stage in-order integer pipeline: the EX/MEM and MEM/WB
// pipeline registers, the load-use hazard detector and the register file
// write port.
//
// Ports
//   clk              : clock; all state updates on its rising edge
//   rst_n            : asynchronous active-low reset, clears every register
//   hold             : global stall, freezes EX/MEM and MEM/WB
//   flush            : turns the next EX/MEM load into a bubble
//   in_valid         : the instruction in ID/EX is valid
//   in_rd            : ID/EX destination register
//   in_regWrite      : ID/EX writes the register file
//   in_memToReg      : ID/EX is a load (result comes from data memory)
//   in_alu           : EX-stage ALU result
//   rs1_ID_EX        : first source register of the instruction in EX
//   rs2_ID_EX        : second source register of the instruction in EX
//   mem_rdata        : data memory read data, valid during MEM
//   rd_EX_MEM        : EX/MEM destination tag       (to forwarding unit)
//   regWrite_EX_MEM  : EX/MEM write enable tag      (to forwarding unit)
//   alu_EX_MEM       : EX/MEM ALU result            (forwarding source)
//   rd_MEM_WB        : MEM/WB destination tag       (to forwarding unit)
//   regWrite_MEM_WB  : MEM/WB write enable tag      (to forwarding unit)
//   wb_data_MEM_WB   : MEM/WB write-back data       (forwarding source)
//   rf_we            : register file write enable (x0 writes suppressed)
//   rf_waddr         : register file write address
//   rf_wdata         : register file write data
//   lu_stall         : load-use stall request to the upstream stages
//   retire_cnt       : count of register file writes (optional, see below)
//
// Configuration
//   RESULT_PIPE_RETIRE_CNT_EN : when defined, adds the retire_cnt output, a
//   32-bit wrapping count of cycles where rf_we=1 and hold=0. When undefined
//   the port and its counter do not exist.
//
// Handshake: there is no valid/ready pair here. in_valid qualifies the
// ID/EX inputs on each rising edge; the upstream stages must keep the same
// instruction presented while lu_stall or hold is high, because the inputs
// are not captured in those cycles.
// ---------------------------------------------------------------------------
module result_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [4:0]  in_rd,
    input  logic        in_regWrite,
    input  logic        in_memToReg,
    input  logic [31:0] in_alu,
    input  logic [4:0]  rs1_ID_EX,
    input  logic [4:0]  rs2_ID_EX,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  rd_EX_MEM,
    output logic [4:0]  rd_MEM_WB,
    output logic        regWrite_EX_MEM,
    output logic        regWrite_MEM_WB,
    output logic [31:0] alu_EX_MEM,
    output logic [31:0] wb_data_MEM_WB,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        lu_stall
`ifdef RESULT_PIPE_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    // -----------------------------------------------------------------------
    // EX/MEM register
    // -----------------------------------------------------------------------
    logic [4:0]  em_rd_q,   em_rd_d;
    logic        em_rw_q,   em_rw_d;
    logic        em_m2r_q,  em_m2r_d;
    logic [31:0] em_alu_q,  em_alu_d;

    // -----------------------------------------------------------------------
    // MEM/WB register
    // -----------------------------------------------------------------------
    logic [4:0]  mw_rd_q,   mw_rd_d;
    logic        mw_rw_q,   mw_rw_d;
    logic [31:0] mw_wb_q,   mw_wb_d;

    // -----------------------------------------------------------------------
    // Load-use hazard detection
    //
    // A load sitting in EX/MEM only has its data at the end of MEM, so a
    // dependent instruction in EX cannot be served by forwarding this cycle.
    // The stall bubbles EX/MEM, which moves the load out of EX/MEM on the
    // same edge; the request therefore drops after exactly one cycle and the
    // dependent instruction picks the data up from MEM/WB forwarding.
    // x0 never creates a dependency. hold and flush mask the request: under
    // hold nothing moves, and under flush EX/MEM is being bubbled anyway.
    // -----------------------------------------------------------------------
    logic load_in_em;
    logic src_match;
    logic hazard;

    always_comb begin
        load_in_em = em_rw_q & em_m2r_q & (em_rd_q != 5'd0);
        src_match  = (em_rd_q == rs1_ID_EX) | (em_rd_q == rs2_ID_EX);
        hazard     = load_in_em & in_valid & src_match;
    end

    assign lu_stall = hazard & ~hold & ~flush;

    // -----------------------------------------------------------------------
    // EX/MEM next state: hold > flush > load-use bubble > capture.
    // An invalid ID/EX slot is captured as a bubble too, so every non-capture
    // case collapses to the same all-zero value.
    // -----------------------------------------------------------------------
    logic em_bubble;

    always_comb begin
        em_bubble = flush | lu_stall | ~in_valid;

        em_rd_d   = em_rd_q;
        em_rw_d   = em_rw_q;
        em_m2r_d  = em_m2r_q;
        em_alu_d  = em_alu_q;

        if (!hold) begin
            if (em_bubble) begin
                em_rd_d  = 5'd0;
                em_rw_d  = 1'b0;
                em_m2r_d = 1'b0;
                em_alu_d = 32'd0;
            end else begin
                em_rd_d  = in_rd;
                em_rw_d  = in_regWrite;
                em_m2r_d = in_memToReg;
                em_alu_d = in_alu;
            end
        end
    end

    // -----------------------------------------------------------------------
    // MEM/WB next state. flush does not reach this stage: the instruction
    // leaving EX/MEM on a flush cycle is older than the flush and retires.
    // regWrite with rd=0 is stored as-is; x0 is filtered only at rf_we so the
    // forwarding unit sees the true tags.
    // -----------------------------------------------------------------------
    always_comb begin
        mw_rd_d = mw_rd_q;
        mw_rw_d = mw_rw_q;
        mw_wb_d = mw_wb_q;

        if (!hold) begin
            mw_rd_d = em_rd_q;
            mw_rw_d = em_rw_q;
            mw_wb_d = em_m2r_q ? mem_rdata : em_alu_q;
        end
    end

    // -----------------------------------------------------------------------
    // Stage registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            em_rd_q  <= 5'd0;
            em_rw_q  <= 1'b0;
            em_m2r_q <= 1'b0;
            em_alu_q <= 32'd0;
            mw_rd_q  <= 5'd0;
            mw_rw_q  <= 1'b0;
            mw_wb_q  <= 32'd0;
        end else begin
            em_rd_q  <= em_rd_d;
            em_rw_q  <= em_rw_d;
            em_m2r_q <= em_m2r_d;
            em_alu_q <= em_alu_d;
            mw_rd_q  <= mw_rd_d;
            mw_rw_q  <= mw_rw_d;
            mw_wb_q  <= mw_wb_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign rd_EX_MEM       = em_rd_q;
    assign regWrite_EX_MEM = em_rw_q;
    assign alu_EX_MEM      = em_alu_q;
    assign rd_MEM_WB       = mw_rd_q;
    assign regWrite_MEM_WB = mw_rw_q;
    assign wb_data_MEM_WB  = mw_wb_q;

    assign rf_we    = mw_rw_q & (mw_rd_q != 5'd0);
    assign rf_waddr = mw_rd_q;
    assign rf_wdata = mw_wb_q;

`ifdef RESULT_PIPE_RETIRE_CNT_EN
    // -----------------------------------------------------------------------
    // Retirement counter. A write only counts when the pipe advances, so a
    // write held in MEM/WB across a hold is counted once, on release.
    // Wraps naturally at 32 bits.
    // -----------------------------------------------------------------------
    logic [31:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (rf_we && !hold) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= 32'd0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_result_pipe.sv
// ---------------------------------------------------------------------------
// tb_result_pipe
//
// Directed bench for result_pipe. A behavioural model holds the two
// in-flight instruction records and is advanced once per rising edge; a
// compare process checks every DUT output against it on each falling edge.
// Literal expectations at the scenario points pin the model itself.
// ---------------------------------------------------------------------------
module tb_result_pipe;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        hold;
  logic        flush;
  logic        in_valid;
  logic [4:0]  in_rd;
  logic        in_regWrite;
  logic        in_memToReg;
  logic [31:0] in_alu;
  logic [4:0]  rs1_ID_EX;
  logic [4:0]  rs2_ID_EX;
  logic [31:0] mem_rdata;
  logic [4:0]  rd_EX_MEM;
  logic [4:0]  rd_MEM_WB;
  logic        regWrite_EX_MEM;
  logic        regWrite_MEM_WB;
  logic [31:0] alu_EX_MEM;
  logic [31:0] wb_data_MEM_WB;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        lu_stall;
`ifdef RESULT_PIPE_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  result_pipe dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hold            (hold),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_rd           (in_rd),
    .in_regWrite     (in_regWrite),
    .in_memToReg     (in_memToReg),
    .in_alu          (in_alu),
    .rs1_ID_EX       (rs1_ID_EX),
    .rs2_ID_EX       (rs2_ID_EX),
    .mem_rdata       (mem_rdata),
    .rd_EX_MEM       (rd_EX_MEM),
    .rd_MEM_WB       (rd_MEM_WB),
    .regWrite_EX_MEM (regWrite_EX_MEM),
    .regWrite_MEM_WB (regWrite_MEM_WB),
    .alu_EX_MEM      (alu_EX_MEM),
    .wb_data_MEM_WB  (wb_data_MEM_WB),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .lu_stall        (lu_stall)
`ifdef RESULT_PIPE_RETIRE_CNT_EN
    ,
    .retire_cnt      (retire_cnt)
`endif
  );

  // -------------------------------------------------------------------------
  // Scoreboard counters and check helper
  // -------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model: one record per in-flight instruction
  // -------------------------------------------------------------------------
  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic        ld;
    logic [31:0] alu;
  } em_t;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] wb;
  } mw_t;

  em_t         m_em;
  mw_t         m_mw;
  logic [31:0] m_cnt;

  task automatic model_reset();
    m_em  = '{5'd0, 1'b0, 1'b0, 32'd0};
    m_mw  = '{5'd0, 1'b0, 32'd0};
    m_cnt = 32'd0;
  endtask

  // The younger instruction in EX needs a value that a load ahead of it
  // has not fetched yet.
  function automatic logic m_lu();
    logic dep;
    dep = in_valid && m_em.rw && m_em.ld && (m_em.rd != 5'd0) &&
          ((m_em.rd == rs1_ID_EX) || (m_em.rd == rs2_ID_EX));
    return dep && !hold && !flush;
  endfunction

  function automatic logic m_we();
    return m_mw.rw && (m_mw.rd != 5'd0);
  endfunction

  task automatic model_step();
    logic lu;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (hold) return;
    if (m_we()) m_cnt = m_cnt + 32'd1;
    lu = m_lu();
    // the older instruction retires into MEM/WB with its final value
    m_mw = '{m_em.rd, m_em.rw, (m_em.ld ? mem_rdata : m_em.alu)};
    if (flush || lu || !in_valid)
      m_em = '{5'd0, 1'b0, 1'b0, 32'd0};
    else
      m_em = '{in_rd, in_regWrite, in_memToReg, in_alu};
  endtask

  // -------------------------------------------------------------------------
  // Compare process: every falling edge
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rd_EX_MEM",       {27'd0, rd_EX_MEM},       {27'd0, m_em.rd});
      chk("regWrite_EX_MEM", {31'd0, regWrite_EX_MEM}, {31'd0, m_em.rw});
      chk("alu_EX_MEM",      alu_EX_MEM,               m_em.alu);
      chk("rd_MEM_WB",       {27'd0, rd_MEM_WB},       {27'd0, m_mw.rd});
      chk("regWrite_MEM_WB", {31'd0, regWrite_MEM_WB}, {31'd0, m_mw.rw});
      chk("wb_data_MEM_WB",  wb_data_MEM_WB,           m_mw.wb);
      chk("rf_we",           {31'd0, rf_we},           {31'd0, m_we()});
      chk("rf_waddr",        {27'd0, rf_waddr},        {27'd0, m_mw.rd});
      chk("rf_wdata",        rf_wdata,                 m_mw.wb);
      chk("lu_stall",        {31'd0, lu_stall},        {31'd0, m_lu()});
`ifdef RESULT_PIPE_RETIRE_CNT_EN
      chk("retire_cnt",      retire_cnt,               m_cnt);
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw,
                       input logic ld, input logic [31:0] alu,
                       input logic [4:0] s1, input logic [4:0] s2);
    in_valid    = v;
    in_rd       = rd;
    in_regWrite = rw;
    in_memToReg = ld;
    in_alu      = alu;
    rs1_ID_EX   = s1;
    rs2_ID_EX   = s2;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 5'd0, 5'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_EX_MEM"},  {27'd0, rd_EX_MEM},       32'd0);
    chk({tag, "_rw_EX_MEM"},  {31'd0, regWrite_EX_MEM}, 32'd0);
    chk({tag, "_alu_EX_MEM"}, alu_EX_MEM,               32'd0);
    chk({tag, "_rd_MEM_WB"},  {27'd0, rd_MEM_WB},       32'd0);
    chk({tag, "_rw_MEM_WB"},  {31'd0, regWrite_MEM_WB}, 32'd0);
    chk({tag, "_wb_MEM_WB"},  wb_data_MEM_WB,           32'd0);
    chk({tag, "_rf_we"},      {31'd0, rf_we},           32'd0);
    chk({tag, "_rf_waddr"},   {27'd0, rf_waddr},        32'd0);
    chk({tag, "_rf_wdata"},   rf_wdata,                 32'd0);
    chk({tag, "_lu_stall"},   {31'd0, lu_stall},        32'd0);
  endtask

  // Directed mixed traffic: {hold, flush, valid, rd, rw, ld, alu, rs1, rs2, rdata}
  typedef struct {
    logic        h;
    logic        f;
    logic        v;
    logic [4:0]  rd;
    logic        rw;
    logic        ld;
    logic [31:0] alu;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[10];

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    hold      = 1'b0;
    flush     = 1'b0;
    mem_rdata = 32'd0;
    idle();
    rst_n = 1'b0;
    model_reset();
    cmp_en = 1'b1;
    #1;
    chk_all_zero("por");
    tick();
    rst_n = 1'b1;

    // ALU chain: rd=5 visible in EX/MEM after one edge, written after two
    drive(1'b1, 5'd5, 1'b1, 1'b0, 32'h1234, 5'd0, 5'd0);
    tick();
    chk("alu_c1_rd_EX_MEM", {27'd0, rd_EX_MEM}, 32'd5);
    chk("alu_c1_alu",       alu_EX_MEM,         32'h1234);
    chk("alu_c1_rf_we",     {31'd0, rf_we},     32'd0);
    idle();
    tick();
    chk("alu_c2_rf_we",    {31'd0, rf_we},    32'd1);
    chk("alu_c2_rf_waddr", {27'd0, rf_waddr}, 32'd5);
    chk("alu_c2_rf_wdata", rf_wdata,          32'h1234);

    // Load-use on rs2: one stall cycle, bubble, load data from memory
    drive(1'b1, 5'd3, 1'b1, 1'b1, 32'h0000AAAA, 5'd0, 5'd0);
    tick();
    mem_rdata = 32'hDEADBEEF;
    drive(1'b1, 5'd8, 1'b1, 1'b0, 32'h808, 5'd7, 5'd3);
    #1;
    chk("lu_on", {31'd0, lu_stall}, 32'd1);
    tick();
    chk("lu_bubble_rd",  {27'd0, rd_EX_MEM},       32'd0);
    chk("lu_bubble_rw",  {31'd0, regWrite_EX_MEM}, 32'd0);
    chk("lu_wb_rd",      {27'd0, rd_MEM_WB},       32'd3);
    chk("lu_wb_data",    wb_data_MEM_WB,           32'hDEADBEEF);
    chk("lu_off",        {31'd0, lu_stall},        32'd0);
    tick();
    chk("lu_dep_capture", {27'd0, rd_EX_MEM}, 32'd8);
    idle();
    tick();

    // Back-to-back dependent loads each stall once
    mem_rdata = 32'h11112222;
    drive(1'b1, 5'd4, 1'b1, 1'b1, 32'h44, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd6, 1'b1, 1'b1, 32'h66, 5'd4, 5'd0);
    #1;
    chk("b2b_lu1_on", {31'd0, lu_stall}, 32'd1);
    tick();
    chk("b2b_lu1_off", {31'd0, lu_stall}, 32'd0);
    mem_rdata = 32'h33334444;
    tick();
    drive(1'b1, 5'd7, 1'b1, 1'b0, 32'h77, 5'd6, 5'd6);
    #1;
    chk("b2b_lu2_on", {31'd0, lu_stall}, 32'd1);
    tick();
    chk("b2b_lu2_off", {31'd0, lu_stall}, 32'd0);
    chk("b2b_wb_data", wb_data_MEM_WB,    32'h33334444);
    tick();
    idle();
    tick();
    tick();

    // Hold for three cycles with a pending load-use: everything frozen
    drive(1'b1, 5'd2, 1'b1, 1'b1, 32'h22, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd9, 1'b1, 1'b0, 32'h99, 5'd2, 5'd0);
    hold = 1'b1;
    #1;
    chk("hold_lu_masked", {31'd0, lu_stall}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_rd_EX_MEM", {27'd0, rd_EX_MEM}, 32'd2);
      chk("hold_alu",       alu_EX_MEM,         32'h22);
      chk("hold_rd_MEM_WB", {27'd0, rd_MEM_WB}, 32'd0);
      chk("hold_lu",        {31'd0, lu_stall},  32'd0);
    end
    hold = 1'b0;
    mem_rdata = 32'h5A5A0001;
    #1;
    chk("hold_release_lu", {31'd0, lu_stall}, 32'd1);
    tick();
    chk("hold_release_wb", wb_data_MEM_WB, 32'h5A5A0001);
    tick();
    idle();
    tick();
    tick();

    // x0 destination: stored write enable passes, rf_we suppressed
    drive(1'b1, 5'd0, 1'b1, 1'b0, 32'h55, 5'd0, 5'd0);
    tick();
    idle();
    tick();
    chk("x0_rw_MEM_WB", {31'd0, regWrite_MEM_WB}, 32'd1);
    chk("x0_rf_we",     {31'd0, rf_we},           32'd0);
    chk("x0_rf_wdata",  rf_wdata,                 32'h55);
    // a load to x0 never creates a dependency
    drive(1'b1, 5'd0, 1'b1, 1'b1, 32'd0, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd1, 1'b1, 1'b0, 32'd1, 5'd0, 5'd0);
    #1;
    chk("x0_load_no_lu", {31'd0, lu_stall}, 32'd0);
    tick();
    idle();
    tick();

    // Flush with hold: hold wins. Flush alone: bubble, older one retires.
    drive(1'b1, 5'd9, 1'b1, 1'b0, 32'h99, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd10, 1'b1, 1'b0, 32'hA0, 5'd0, 5'd0);
    hold  = 1'b1;
    flush = 1'b1;
    tick();
    chk("fh_rd_EX_MEM", {27'd0, rd_EX_MEM}, 32'd9);
    chk("fh_alu",       alu_EX_MEM,         32'h99);
    hold = 1'b0;
    tick();
    chk("fl_rd_EX_MEM", {27'd0, rd_EX_MEM}, 32'd0);
    chk("fl_alu",       alu_EX_MEM,         32'd0);
    chk("fl_rd_MEM_WB", {27'd0, rd_MEM_WB}, 32'd9);
    chk("fl_rf_we",     {31'd0, rf_we},     32'd1);
    chk("fl_rf_wdata",  rf_wdata,           32'h99);
    flush = 1'b0;
    tick();
    idle();
    tick();

    // Mixed directed traffic checked by the model only
    vecs[0] = '{1'b0, 1'b0, 1'b1, 5'd11, 1'b1, 1'b1, 32'hB0B0, 5'd0,  5'd0,  32'hC0FFEE00};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 5'd12, 1'b1, 1'b0, 32'hB1B1, 5'd11, 5'd1,  32'hC0FFEE01};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 5'd12, 1'b1, 1'b0, 32'hB1B1, 5'd11, 5'd1,  32'hC0FFEE02};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 5'd13, 1'b1, 1'b1, 32'hB3B3, 5'd12, 5'd12, 32'hC0FFEE03};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 5'd14, 1'b1, 1'b1, 32'hB4B4, 5'd2,  5'd3,  32'hC0FFEE04};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 5'd15, 1'b0, 1'b0, 32'hB5B5, 5'd14, 5'd0,  32'hC0FFEE05};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 5'd15, 1'b0, 1'b0, 32'hB5B5, 5'd14, 5'd0,  32'hC0FFEE06};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 5'd16, 1'b1, 1'b0, 32'hB7B7, 5'd0,  5'd0,  32'hC0FFEE07};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 5'd17, 1'b0, 1'b0, 32'hB8B8, 5'd0,  5'd0,  32'hC0FFEE08};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 5'd18, 1'b1, 1'b0, 32'hB9B9, 5'd17, 5'd17, 32'hC0FFEE09};
    for (int i = 0; i < 10; i++) begin
      hold      = vecs[i].h;
      flush     = vecs[i].f;
      mem_rdata = vecs[i].rdata;
      drive(vecs[i].v, vecs[i].rd, vecs[i].rw, vecs[i].ld, vecs[i].alu,
            vecs[i].s1, vecs[i].s2);
      tick();
    end
    hold  = 1'b0;
    flush = 1'b0;
    idle();
    tick();
    tick();

    // Asynchronous reset mid-stream with a load-use pending
    drive(1'b1, 5'd12, 1'b1, 1'b0, 32'hC, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd13, 1'b1, 1'b1, 32'hD, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd14, 1'b1, 1'b0, 32'hE, 5'd13, 5'd0);
    #1;
    chk("pre_rst_lu", {31'd0, lu_stall}, 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all_zero("async_rst");
    tick();
    rst_n = 1'b1;
    drive(1'b1, 5'd15, 1'b1, 1'b0, 32'hF, 5'd0, 5'd0);
    tick();
    chk("post_rst_capture", {27'd0, rd_EX_MEM}, 32'd15);
    idle();
    tick();
    chk("post_rst_rf_we",    {31'd0, rf_we}, 32'd1);
    chk("post_rst_rf_wdata", rf_wdata,       32'hF);
    tick();
    tick();

    @(negedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
